stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch. It consumes the divided level clocks from the clock divider (1 Hz-class seconds clock, kHz-class scan clock) and pushbutton inputs. It sequences run/pause/clear/adjust of an MM:SS BCD time register and schedules the 4-digit multiplexed display. The module runs entirely in the system clock domain. The divider outputs are treated as data and turned into single-cycle enables, never used as clocks.

---
 rtl/stopwatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/clear/adjust sequencing of an MM:SS BCD time register plus 4-digit display scan.
// Latency: sec_clk rise -> sec_en 3 clk, time update on the next edge; debounced press -> state change 1 clk.
// Backpressure: none; every conditioned enable and press event is acted on in the cycle it appears.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sec_clk, scan_clk   divider square waves, sampled as data and edge-detected
//   btn_start/reset/sel/adj  raw active-high pushbuttons
//   time_bcd            {min_tens, min_ones, sec_tens, sec_ones}
//   digit, an           scanned digit value and active-low one-hot anode enable
//   state, running      FSM state code and RUN indicator
module stopwatch_ctrl #(
    parameter int DB_SAMPLES = 4,
    parameter int MIN_MAX    = 99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_clk,
    input  logic        scan_clk,
    input  logic        btn_start,
    input  logic        btn_reset,
    input  logic        btn_sel,
    input  logic        btn_adj,
    output logic [15:0] time_bcd,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic [2:0]  state,
    output logic        running
);

    localparam int             CW     = $clog2(DB_SAMPLES + 1);
    localparam logic [CW-1:0]  DB_MAX = CW'(DB_SAMPLES);
    localparam logic [7:0]     MIN_LIM = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

    // Button vector index: 0 start, 1 reset, 2 sel, 3 adj
    localparam int B_START = 0;
    localparam int B_RESET = 1;
    localparam int B_SEL   = 2;
    localparam int B_ADJ   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_ADJ_MIN = 3'd3,
        ST_ADJ_SEC = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers, registered rising-edge pulses
    // ------------------------------------------------------------------
    logic [1:0] sec_sync;
    logic [1:0] scan_sync;
    logic       sec_prev;
    logic       scan_prev;
    logic       sec_en;
    logic       scan_en;
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;
    logic [3:0] btn_raw;

    assign btn_raw = {btn_adj, btn_sel, btn_reset, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_sync  <= 2'b00;
            scan_sync <= 2'b00;
            sec_prev  <= 1'b0;
            scan_prev <= 1'b0;
            sec_en    <= 1'b0;
            scan_en   <= 1'b0;
            btn_meta  <= 4'b0000;
            btn_sync  <= 4'b0000;
        end else begin
            sec_sync  <= {sec_sync[0], sec_clk};
            scan_sync <= {scan_sync[0], scan_clk};
            sec_prev  <= sec_sync[1];
            scan_prev <= scan_sync[1];
            sec_en    <= sec_sync[1] & ~sec_prev;
            scan_en   <= scan_sync[1] & ~scan_prev;
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debounce. A button is only armed once it has been sampled low, so a
    // button already held when reset releases never produces an event.
    // ------------------------------------------------------------------
    logic [CW-1:0] db_cnt [4];
    logic [3:0]    db_lvl;
    logic [3:0]    db_prev;
    logic [3:0]    armed;
    logic [3:0]    press;

    always_comb begin
        db_lvl = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            db_lvl[i] = (db_cnt[i] == DB_MAX);
        end
    end

    assign press = db_lvl & ~db_prev & armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            db_prev <= 4'b0000;
            armed   <= 4'b0000;
        end else begin
            db_prev <= db_lvl;
            if (scan_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (btn_sync[i]) begin
                        if (db_cnt[i] != DB_MAX) begin
                            db_cnt[i] <= db_cnt[i] + 1'b1;
                        end
                    end else begin
                        db_cnt[i] <= '0;
                        armed[i]  <= 1'b1;
                    end
                end
            end
        end
    end

    // Only the highest-priority event in a cycle survives
    logic ev_reset;
    logic ev_start;
    logic ev_sel;
    logic ev_adj;

    assign ev_reset = press[B_RESET];
    assign ev_start = press[B_START] & ~press[B_RESET];
    assign ev_sel   = press[B_SEL] & ~press[B_START] & ~press[B_RESET];
    assign ev_adj   = press[B_ADJ] & ~press[B_SEL] & ~press[B_START] & ~press[B_RESET];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (ev_reset) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ev_start)    state_nxt = ST_RUN;
                    else if (ev_sel) state_nxt = ST_ADJ_MIN;
                end
                ST_RUN: begin
                    if (ev_start) state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (ev_start)    state_nxt = ST_RUN;
                    else if (ev_sel) state_nxt = ST_ADJ_MIN;
                end
                ST_ADJ_MIN: begin
                    if (ev_start)    state_nxt = ST_RUN;
                    else if (ev_sel) state_nxt = ST_ADJ_SEC;
                end
                ST_ADJ_SEC: begin
                    if (ev_start)    state_nxt = ST_RUN;
                    else if (ev_sel) state_nxt = ST_PAUSE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Time register (two BCD bytes)
    // ------------------------------------------------------------------
    function automatic logic [7:0] sec_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (s[7:4] == 4'd5) ? 4'd0 : s[7:4] + 4'd1;
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m == MIN_LIM) begin
            r = 8'h00;
        end else if (m[3:0] == 4'd9) begin
            r = {m[7:4] + 4'd1, 4'd0};
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic [7:0] min_nxt;
    logic [7:0] sec_nxt;

    // Counting keys off the registered state, so a tick still lands in the
    // cycle that a start event pauses the watch; a reset event overrides it.
    always_comb begin
        min_nxt = min_q;
        sec_nxt = sec_q;
        if (ev_reset) begin
            min_nxt = 8'h00;
            sec_nxt = 8'h00;
        end else if (state_q == ST_RUN && sec_en) begin
            sec_nxt = sec_inc(sec_q);
            if (sec_q == 8'h59) begin
                min_nxt = min_inc(min_q);
            end
        end else if (ev_adj && state_q == ST_ADJ_MIN) begin
            min_nxt = min_inc(min_q);
        end else if (ev_adj && state_q == ST_ADJ_SEC) begin
            sec_nxt = sec_inc(sec_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 8'h00;
            sec_q <= 8'h00;
        end else begin
            min_q <= min_nxt;
            sec_q <= sec_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Blink: free-running on sec_en, restarted dark-free on entering an
    // adjust field so the freshly selected field is visible immediately.
    // ------------------------------------------------------------------
    logic blink_q;
    logic blink_nxt;
    logic enter_adj;

    assign enter_adj = ((state_nxt == ST_ADJ_MIN) && (state_q != ST_ADJ_MIN)) ||
                       ((state_nxt == ST_ADJ_SEC) && (state_q != ST_ADJ_SEC));

    always_comb begin
        blink_nxt = blink_q;
        if (enter_adj) begin
            blink_nxt = 1'b0;
        end else if (sec_en) begin
            blink_nxt = ~blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Display scan: index advances on scan_en; an/digit are registered
    // from the index so they follow it one edge later.
    // ------------------------------------------------------------------
    logic [1:0] scan_idx;
    logic [3:0] an_nxt;
    logic [3:0] digit_nxt;
    logic [3:0] an_q;
    logic [3:0] digit_q;
    logic       blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= 2'd0;
        end else if (scan_en) begin
            scan_idx <= scan_idx + 2'd1;
        end
    end

    always_comb begin
        an_nxt    = 4'b1110;
        digit_nxt = sec_q[3:0];
        unique case (scan_idx)
            2'd0: begin an_nxt = 4'b1110; digit_nxt = sec_q[3:0]; end
            2'd1: begin an_nxt = 4'b1101; digit_nxt = sec_q[7:4]; end
            2'd2: begin an_nxt = 4'b1011; digit_nxt = min_q[3:0]; end
            default: begin an_nxt = 4'b0111; digit_nxt = min_q[7:4]; end
        endcase
        blank = blink_q && (((state_q == ST_ADJ_MIN) && scan_idx[1]) ||
                            ((state_q == ST_ADJ_SEC) && !scan_idx[1]));
        if (blank) begin
            an_nxt = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q    <= 4'b1110;
            digit_q <= 4'd0;
        end else begin
            an_q    <= an_nxt;
            digit_q <= digit_nxt;
        end
    end

    assign time_bcd = {min_q, sec_q};
    assign digit    = digit_q;
    assign an       = an_q;
    assign state    = state_q;
    assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic        clk;
    logic        rst_n;
    logic        sec_clk;
    logic        scan_clk;
    logic [3:0]  btns;          // {adj, sel, reset, start}
    logic [15:0] time_bcd;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [2:0]  state;
    logic        running;

    stopwatch_ctrl #(.DB_SAMPLES(DB), .MIN_MAX(99)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_clk   (sec_clk),
        .scan_clk  (scan_clk),
        .btn_start (btns[0]),
        .btn_reset (btns[1]),
        .btn_sel   (btns[2]),
        .btn_adj   (btns[3]),
        .time_bcd  (time_bcd),
        .digit     (digit),
        .an        (an),
        .state     (state),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mask: bit0 state(+running), bit1 time_bcd, bit2 an, bit3 digit
    typedef struct packed {
        logic [3:0]  mask;
        logic [2:0]  st;
        logic [15:0] tb;
        logic [3:0]  an;
        logic [3:0]  dg;
        logic [7:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   scan_cnt = 0;

    // Monitor: pops one expectation per falling edge and compares
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.mask[0]) begin
                n_chk++;
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL chk%0d state: got %0d expected %0d", e.tag, state, e.st);
                end
                n_chk++;
                if (running !== (e.st == 3'd1)) begin
                    n_fail++;
                    $display("FAIL chk%0d running: got %0b expected %0b", e.tag, running, e.st == 3'd1);
                end
            end
            if (e.mask[1]) begin
                n_chk++;
                if (time_bcd !== e.tb) begin
                    n_fail++;
                    $display("FAIL chk%0d time_bcd: got %h expected %h", e.tag, time_bcd, e.tb);
                end
            end
            if (e.mask[2]) begin
                n_chk++;
                if (an !== e.an) begin
                    n_fail++;
                    $display("FAIL chk%0d an: got %b expected %b", e.tag, an, e.an);
                end
            end
            if (e.mask[3]) begin
                n_chk++;
                if (digit !== e.dg) begin
                    n_fail++;
                    $display("FAIL chk%0d digit: got %0d expected %0d", e.tag, digit, e.dg);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input logic [3:0] mask, input logic [2:0] st, input logic [15:0] tb,
                            input logic [3:0] a, input logic [3:0] d, input int tag);
        exp_t e;
        e.mask = mask;
        e.st   = st;
        e.tb   = tb;
        e.an   = a;
        e.dg   = d;
        e.tag  = 8'(tag);
        exp_q.push_back(e);
        tick(1);
    endtask

    task automatic exp_st_tm(input logic [2:0] st, input logic [15:0] tb, input int tag);
        expect_o(4'b0011, st, tb, 4'h0, 4'h0, tag);
    endtask

    task automatic scan_pulse();
        scan_clk = 1'b1;
        tick(3);
        scan_clk = 1'b0;
        tick(3);
        scan_cnt++;
    endtask

    task automatic sec_pulse();
        sec_clk = 1'b1;
        tick(3);
        sec_clk = 1'b0;
        tick(3);
    endtask

    task automatic press(input logic [3:0] which);
        btns = which;
        repeat (DB + 1) scan_pulse();
        btns = 4'b0000;
        scan_pulse();
        tick(2);
    endtask

    localparam logic [3:0] P_START = 4'b0001;
    localparam logic [3:0] P_RESET = 4'b0010;
    localparam logic [3:0] P_SEL   = 4'b0100;
    localparam logic [3:0] P_ADJ   = 4'b1000;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    logic [3:0] an_exp  [8];
    logic [3:0] dig_exp [4];

    initial begin
        rst_n    = 1'b0;
        sec_clk  = 1'b0;
        scan_clk = 1'b0;
        btns     = 4'b1111;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset values with all buttons held
        expect_o(4'b1111, 3'd0, 16'h0000, 4'b1110, 4'd0, 1);
        // Held buttons debounce high but were never seen low: no event
        repeat (DB + 2) scan_pulse();
        tick(2);
        exp_st_tm(3'd0, 16'h0000, 2);
        btns = 4'b0000;
        scan_pulse();
        tick(2);
        exp_st_tm(3'd0, 16'h0000, 3);

        // Run for 75 s, then pause
        press(P_START);
        exp_st_tm(3'd1, 16'h0000, 4);
        repeat (75) sec_pulse();
        exp_st_tm(3'd1, 16'h0115, 5);
        press(P_START);
        exp_st_tm(3'd2, 16'h0115, 6);
        repeat (3) sec_pulse();
        exp_st_tm(3'd2, 16'h0115, 7);

        // Adjust from PAUSE
        press(P_SEL);
        exp_st_tm(3'd3, 16'h0115, 8);
        repeat (3) press(P_ADJ);
        exp_st_tm(3'd3, 16'h0415, 9);
        press(P_SEL);
        exp_st_tm(3'd4, 16'h0415, 10);
        repeat (61) press(P_ADJ);
        exp_st_tm(3'd4, 16'h0416, 11);
        press(P_SEL);
        exp_st_tm(3'd2, 16'h0416, 12);

        // Clear, preload 99:58, run across the wrap
        press(P_RESET);
        exp_st_tm(3'd0, 16'h0000, 13);
        press(P_SEL);
        repeat (99) press(P_ADJ);
        exp_st_tm(3'd3, 16'h9900, 14);
        press(P_SEL);
        repeat (58) press(P_ADJ);
        exp_st_tm(3'd4, 16'h9958, 15);
        press(P_START);
        exp_st_tm(3'd1, 16'h9958, 16);
        sec_pulse();
        exp_st_tm(3'd1, 16'h9959, 17);
        sec_pulse();
        exp_st_tm(3'd1, 16'h0000, 18);
        sec_pulse();
        exp_st_tm(3'd1, 16'h0001, 19);

        // Bounce 1-0-1 shorter than DB samples: no event
        btns = P_START;
        repeat (2) scan_pulse();
        btns = 4'b0000;
        scan_pulse();
        btns = P_START;
        repeat (2) scan_pulse();
        btns = 4'b0000;
        repeat (2) scan_pulse();
        tick(2);
        exp_st_tm(3'd1, 16'h0001, 20);

        // Start and reset in the same cycle: reset wins
        press(P_START | P_RESET);
        exp_st_tm(3'd0, 16'h0000, 21);

        // Set 12:34 and look at the scan in ADJ_SEC over two blink phases
        press(P_SEL);
        repeat (12) press(P_ADJ);
        press(P_SEL);
        repeat (34) press(P_ADJ);
        exp_st_tm(3'd4, 16'h1234, 22);
        while (scan_cnt % 4 != 3) scan_pulse();
        tick(2);

        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    4'b1111, 4'b1111, 4'b1011, 4'b0111};
        dig_exp = '{4'd4, 4'd3, 4'd2, 4'd1};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                sec_pulse();     // blink -> 1, time must not count here
                exp_st_tm(3'd4, 16'h1234, 30);
            end
            scan_pulse();
            tick(2);
            expect_o(4'b1100, 3'd0, 16'h0000, an_exp[k], dig_exp[k % 4], 40 + k);
        end

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick(1);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
